// File: rtl/bcd_line_encoder.sv
// Ten-line active-low keypad encoder: synchronize, debounce, encode single presses to BCD, queue in a FIFO.
// Optional macro BCD_ENC_PARITY_EN adds a stored odd-parity bit and the code_par output.
module bcd_line_encoder #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] line_n,
    output logic [3:0] code,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       err,
    output logic       overflow
`ifdef BCD_ENC_PARITY_EN
    ,
    output logic       code_par
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = 4;
    localparam int unsigned RW = 5;
`ifdef BCD_ENC_PARITY_EN
    localparam int unsigned EW = 5;
    localparam logic [EW-1:0] RESET_ENTRY = 5'b1_0000;
`else
    localparam int unsigned EW = 4;
    localparam logic [EW-1:0] RESET_ENTRY = 4'b0000;
`endif

    typedef enum logic {
        IDLE,
        PRESSED
    } state_t;

    logic [9:0]    sync1;
    logic [9:0]    s;
    logic [9:0]    s_prev;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [RW-1:0] run;
    logic          accept_c;

    logic [3:0]    zeros;
    logic [3:0]    key;

    state_t        state;
    state_t        state_next;
    logic          push_req;
    logic          err_set;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr_next;
    logic [PW-1:0] rptr_next;
    logic          full;
    logic          empty;
    logic          pop;
    logic          wr;
    logic          ovf_set;
    logic [EW-1:0] wdata;
    logic [EW-1:0] head_next;
    logic [AW-1:0] ridx_next;

    // Two-flop synchronizer plus one-cycle history for change detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '1;
            s      <= '1;
            s_prev <= '1;
            cnt    <= '0;
        end else begin
            sync1  <= line_n;
            s      <= sync1;
            s_prev <= s;
            cnt    <= cnt_next;
        end
    end

    // Run length of the current pattern, including this cycle; saturates so acceptance fires once
    always_comb begin
        run      = (s != s_prev) ? RW'(1) : (RW'(cnt) + RW'(1));
        accept_c = (run == RW'(STABLE_CYCLES));
        cnt_next = (run > RW'(STABLE_CYCLES)) ? CW'(STABLE_CYCLES) : run[CW-1:0];
    end

    always_comb begin
        zeros = '0;
        key   = '0;
        for (int k = 0; k < 10; k++) begin
            if (!s[k]) begin
                zeros = zeros + 4'd1;
                key   = 4'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        push_req   = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c && zeros == 4'd1) begin
                    push_req   = 1'b1;
                    state_next = PRESSED;
                end else if (accept_c && zeros > 4'd1) begin
                    err_set    = 1'b1;
                    state_next = PRESSED;
                end
            end
            PRESSED: begin
                if (accept_c && zeros == 4'd0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FIFO control; a pop on a full FIFO frees room for a same-edge push
    always_comb begin
        empty     = (wptr == rptr);
        full      = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
        pop       = !empty && code_ready;
        wr        = push_req && (!full || pop);
        ovf_set   = push_req && full && !pop;
`ifdef BCD_ENC_PARITY_EN
        wdata     = {~^key, key};
`else
        wdata     = key;
`endif
        wptr_next = wptr + PW'(wr);
        rptr_next = rptr + PW'(pop);
        ridx_next = rptr_next[AW-1:0];
        head_next = (wr && wptr[AW-1:0] == ridx_next) ? wdata : mem[ridx_next];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= RESET_ENTRY;
            end
        end else if (wr) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    // Outputs are registered from the post-edge FIFO state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            err        <= 1'b0;
            overflow   <= 1'b0;
`ifdef BCD_ENC_PARITY_EN
            code_par   <= 1'b1;
`endif
        end else begin
            wptr       <= wptr_next;
            rptr       <= rptr_next;
            code       <= head_next[3:0];
            code_valid <= (wptr_next != rptr_next);
            err        <= err_set;
            overflow   <= overflow | ovf_set;
`ifdef BCD_ENC_PARITY_EN
            code_par   <= head_next[4];
`endif
        end
    end

endmodule

// File: tb/tb_bcd_line_encoder.sv
// Self-checking bench for bcd_line_encoder: scenario tasks plus a scoreboard that checks every popped code.
module tb_bcd_line_encoder;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned STABLE = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] line_n;
    logic [3:0] code;
    logic       code_valid;
    logic       code_ready;
    logic       err;
    logic       overflow;
`ifdef BCD_ENC_PARITY_EN
    logic       code_par;
`endif

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;

    bcd_line_encoder #(.DEPTH(DEPTH), .STABLE_CYCLES(STABLE)) dut (
        .clk(clk),
        .rst(rst),
        .line_n(line_n),
        .code(code),
        .code_valid(code_valid),
        .code_ready(code_ready),
        .err(err),
        .overflow(overflow)
`ifdef BCD_ENC_PARITY_EN
        ,
        .code_par(code_par)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard: every handshake compares the head against the oldest expected code
    always @(negedge clk) begin
        if (!rst && code_valid && code_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got code %0d, expected no valid entry", code);
            end else begin
                mon_exp = exp_q.pop_front();
                if (code !== mon_exp) begin
                    n_fail++;
                    $display("FAIL pop_code: got %0d, expected %0d", code, mon_exp);
                end
`ifdef BCD_ENC_PARITY_EN
                if (code_par !== ~^mon_exp) begin
                    n_fail++;
                    $display("FAIL pop_parity: got %b, expected %b", code_par, ~^mon_exp);
                end
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int d, input int hold);
        logic [9:0] pat;
        pat    = '1;
        pat[d] = 1'b0;
        line_n = pat;
        tick(hold);
        line_n = '1;
        tick(5);
    endtask

    task automatic wait_drain(output bit ok);
        int budget;
        budget     = 60;
        code_ready = 1'b1;
        while (exp_q.size() != 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        tick(1);
        code_ready = 1'b0;
        ok = (exp_q.size() == 0);
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        line_n     = '1;
        code_ready = 1'b0;
        tick(2);
        n_tests++; if (code !== 4'd0) begin n_fail++; $display("FAIL reset_code: got %0d, expected 0", code); end
        n_tests++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", code_valid); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, expected 0", err); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
`ifdef BCD_ENC_PARITY_EN
        n_tests++; if (code_par !== 1'b1) begin n_fail++; $display("FAIL reset_parity: got %b, expected 1", code_par); end
`endif
        rst = 1'b0;
        tick(4);
    endtask

    task automatic test_single;
        line_n = 10'h37F;
        tick(3);
        n_tests++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got valid %b, expected 0", code_valid); end
        tick(1);
        n_tests++; if (code_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b, expected 1", code_valid); end
        n_tests++; if (code !== 4'd7) begin n_fail++; $display("FAIL single_code: got %0d, expected 7", code); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b, expected 0", err); end
        exp_q.push_back(4'd7);
        line_n     = '1;
        code_ready = 1'b1;
        tick(1);
        code_ready = 1'b0;
        n_tests++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop: got valid %b, expected 0", code_valid); end
        tick(5);
    endtask

    task automatic test_glitch;
        int errs;
        bit ok;
        errs   = 0;
        line_n = 10'h3F7;
        tick(1);
        line_n = '1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            errs += int'(err);
        end
        n_tests++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b, expected 0", code_valid); end
        n_tests++; if (errs != 0) begin n_fail++; $display("FAIL glitch_err: got %0d pulses, expected 0", errs); end
        press(2, 4);
        exp_q.push_back(4'd2);
        n_tests++; if (code_valid !== 1'b1) begin n_fail++; $display("FAIL glitch_then_press: got valid %b, expected 1", code_valid); end
        wait_drain(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL glitch_drain: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_multi;
        int errs;
        bit ok;
        errs   = 0;
        line_n = 10'h3F6;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            errs += int'(err);
        end
        line_n = '1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            errs += int'(err);
        end
        n_tests++; if (errs != 1) begin n_fail++; $display("FAIL multi_err: got %0d pulses, expected 1", errs); end
        n_tests++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL multi_nopush: got valid %b, expected 0", code_valid); end
        press(5, 4);
        exp_q.push_back(4'd5);
        wait_drain(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL multi_drain: got %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_held_second;
        int errs;
        bit ok;
        errs   = 0;
        line_n = 10'h3EF;
        tick(6);
        line_n = 10'h3AF;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            errs += int'(err);
        end
        line_n = '1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            errs += int'(err);
        end
        exp_q.push_back(4'd4);
        n_tests++; if (errs != 0) begin n_fail++; $display("FAIL held_err: got %0d pulses, expected 0", errs); end
        wait_drain(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL held_drain: got %0d left, expected 0", exp_q.size()); end
        n_tests++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL held_single_push: got valid %b, expected 0", code_valid); end
    endtask

    task automatic test_overflow;
        bit ok;
        code_ready = 1'b0;
        for (int d = 1; d <= 5; d++) begin
            press(d, 4);
            if (exp_q.size() < DEPTH) exp_q.push_back(4'(d));
        end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b, expected 1", overflow); end
        wait_drain(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL ovf_drain: got %0d left, expected 0", exp_q.size()); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b, expected 1", overflow); end
    endtask

    task automatic test_full_pop;
        bit ok;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_reset_ovf: got %b, expected 0", overflow); end
        for (int d = 6; d <= 9; d++) begin
            press(d, 4);
            exp_q.push_back(4'(d));
        end
        line_n = 10'h3FE;
        tick(3);
        n_tests++; if (code_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %b, expected 1", code_valid); end
        exp_q.push_back(4'd0);
        code_ready = 1'b1;
        tick(1);
        code_ready = 1'b0;
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pop_ovf: got %b, expected 0", overflow); end
        tick(1);
        line_n = '1;
        tick(5);
        wait_drain(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL full_drain: got %0d left, expected 0", exp_q.size()); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_ovf_after: got %b, expected 0", overflow); end
    endtask

    task automatic test_wrap;
        bit ok;
        int bad;
        bad = 0;
        for (int r = 0; r < 6; r++) begin
            press((r * 3) % 10, 4);
            exp_q.push_back(4'((r * 3) % 10));
            press((r * 7 + 1) % 10, 4);
            exp_q.push_back(4'((r * 7 + 1) % 10));
            wait_drain(ok);
            if (!ok) bad++;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL wrap_drain: got %0d stuck rounds, expected 0", bad); end
        n_tests++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: got valid %b, expected 0", code_valid); end
    endtask

    task automatic test_reset_midop;
        bit found;
        bit ok;
        press(1, 4);
        exp_q.push_back(4'd1);
        press(2, 4);
        exp_q.push_back(4'd2);
        line_n = 10'h1FF;
        tick(2);
        rst = 1'b1;
        #1;
        n_tests++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, expected 0", code_valid); end
        n_tests++; if (code !== 4'd0) begin n_fail++; $display("FAIL midrst_code: got %0d, expected 0", code); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b, expected 0", err); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_ovf: got %b, expected 0", overflow); end
        exp_q.delete();
        tick(2);
        rst   = 1'b0;
        found = 1'b0;
        for (int c = 1; c <= 1 + int'(STABLE) + 1; c++) begin
            tick(1);
            if (code_valid) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL midrst_repress: got no push, expected push within %0d cycles", 2 + STABLE); end
        n_tests++; if (code !== 4'd9) begin n_fail++; $display("FAIL midrst_code9: got %0d, expected 9", code); end
        exp_q.push_back(4'd9);
        line_n = '1;
        tick(5);
        wait_drain(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL midrst_drain: got %0d left, expected 0", exp_q.size()); end
    endtask

    initial begin
        rst        = 1'b1;
        line_n     = '1;
        code_ready = 1'b0;
        test_reset();
        test_single();
        test_glitch();
        test_multi();
        test_held_second();
        test_overflow();
        test_full_pop();
        test_wrap();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_line_encoder.md
# bcd_line_encoder

Reverse-direction companion to the BCD-to-decimal line decoder. It accepts ten active-low decimal lines, such as keypad rows or decoder-style one-of-ten signals, and synchronizes and debounces them. Each clean single-line press is encoded into a 4-bit BCD code and queued in a small FIFO, which a downstream consumer drains over a valid/ready handshake. Multi-line presses and queue overflow are flagged rather than encoded.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- STABLE_CYCLES, 2, consecutive cycles a synchronized pattern must hold before it is acted on; 1..15.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- line_n  input  10  decimal lines, active low; line_n[k]=0 means digit k is pressed.
- code  output  4  BCD digit at FIFO head, 0..9.
- code_valid  output  1  FIFO non-empty.
- code_ready  input  1  consumer accepts head when code_valid && code_ready.
- err  output  1  one-cycle pulse: an accepted pattern had two or more lines low.
- overflow  output  1  sticky: a press was dropped because the FIFO was full. Cleared only by rst.

## Operation
- Synchronizer: two flops per line, reset to all ones (idle). The synchronized vector is s.
- Debounce: a counter tracks how long s has been unchanged and resets whenever s differs from its previous value. A pattern is "accepted" on the cycle s has held for STABLE_CYCLES consecutive cycles. Acceptance fires once per pattern.
- FSM states:
  - IDLE: waiting for a press.
  - PRESSED: a press has been handled; waiting for release.
- Transitions:
  - IDLE, accepted pattern with exactly one zero at index k: push k as 4-bit binary, go to PRESSED.
  - IDLE, accepted pattern with more than one zero: pulse err, no push, go to PRESSED.
  - IDLE, accepted all-ones pattern: no action.
  - PRESSED, accepted all-ones pattern: go to IDLE.
  - PRESSED, any other accepted pattern: ignored. A second key added while one is held produces no push and no err.
- Push when full: the entry is discarded, overflow sets, and the FSM still moves to PRESSED.
- FIFO:
  - Circular, DEPTH entries.
  - Read and write pointers are log2(DEPTH)+1 bits; the MSB distinguishes full from empty.
  - Pointers wrap modulo 2*DEPTH.
  - code is driven from the head entry. It is don't-care while code_valid=0, but must not be X after reset (storage resets to 0).
- Simultaneous push and pop:
  - Full: both occur, and the push is accepted (not an overflow).
  - Empty: the push occurs and the pop is ignored (there is no valid head). There is no bypass.
- Reset values:
  - code=0, code_valid=0, err=0, overflow=0.
  - FSM=IDLE, pointers=0, synchronizer=all ones, debounce counter=0.
- Reset mid-operation: all queued codes are lost. A line still held low after rst deasserts is treated as a new press.

## Timing
- line_n changes just before edge E0. Then:
  - s reflects the change after E1.
  - Acceptance is registered at edge E0+1+STABLE_CYCLES.
  - The FIFO write and err pulse occur at that same edge.
  - code_valid is high after that edge. With the default, that is after E3.
- A glitch shorter than STABLE_CYCLES cycles at s is never accepted.
- Pop takes effect at the edge where code_valid && code_ready. The next entry (or code_valid=0) is visible after that edge.
- err is high for exactly one cycle per offending press.
- Throughput: at most one push per press/release pair. The minimum spacing is 2*STABLE_CYCLES cycles.

## Configuration
- BCD_ENC_PARITY_EN defined:
  - Adds output code_par (1 bit): odd parity over the FIFO head.
  - Each entry is stored as 5 bits (code + parity).
  - code_par resets to 1, the odd parity of 0000.
- Undefined: the code_par port and the extra storage bit are absent. All other behaviour is identical.

## Test plan
- Reset, then press digit 7: line_n=10'h37F held 4 cycles, then released (3FF). Expect code_valid high 3 cycles after the change, code=4'd7, err=0. With code_ready=1, code_valid drops after one pop.
- One-cycle glitch on line 3 (10'h3F7 for a single cycle): no push, code_valid stays 0, FSM remains IDLE.
- Multi-press (10'h3F6, lines 0 and 3) held 4 cycles: err pulses exactly one cycle, no push. After release, a press of 5 pushes code=5.
- With code_ready=0, press/release digits 1,2,3,4,5 (DEPTH=4): four codes are queued and the fifth is dropped, so overflow=1. Draining yields 1,2,3,4 in order; overflow remains 1.
- FIFO full with a press completing on the same edge as a pop: no overflow, and the new code appears after the remaining three. Pointer wrap is checked across 10 or more push/pop cycles.
- Assert rst while 2 codes are queued and digit 9 is held: outputs return to reset values immediately. After deassert, digit 9 pushes code=9 within 1+STABLE_CYCLES+1 cycles.
